// File: rtl/ascon_decrypt_core.sv
// ---------------------------------------------------------------------------
// ascon_decrypt_core
//
// Ascon-128 authenticated decryption datapath. Runs initialisation, AD
// absorption, ciphertext absorption and finalisation with one permutation
// round per clock. Plaintext is streamed out one 64-bit beat per accepted
// ciphertext beat and the received tag is checked at the end.
//
// Ports
//   clock_i      rising-edge clock
//   resetb_i     synchronous, active-high reset
//   start_i      start a decryption (only honoured while idle)
//   key_i        128-bit key, captured on start
//   nonce_i      128-bit nonce, captured on start
//   ad_none_i    no associated data, captured on start
//   ad_*         AD stream (valid/ready), pre-padded 64-bit blocks
//   ct_*         ciphertext stream (valid/ready); last beat carries 0..7 bytes
//   pt_valid_o   one-cycle pulse qualifying pt_data_o
//   pt_data_o    plaintext beat, unused bytes of the last beat are zero
//   tag_i        expected tag, captured with the last ciphertext beat
//   done_o       one-cycle pulse when finalisation completes
//   tag_ok_o     tag comparison result, held until the next start
//   busy_o       high whenever a decryption is in progress
//
// Optional build macro
//   ASCON_DEC_STATE_DBG_EN adds dbg_state_o (full 320-bit state) and
//   dbg_round_o (round counter). Core behaviour is unchanged.
// ---------------------------------------------------------------------------
module ascon_decrypt_core #(
  parameter int ROUNDS_A = 12,
  parameter int ROUNDS_B = 6
) (
  input  logic         clock_i,
  input  logic         resetb_i,
  input  logic         start_i,
  input  logic [127:0] key_i,
  input  logic [127:0] nonce_i,
  input  logic         ad_none_i,
  input  logic         ad_valid_i,
  input  logic [63:0]  ad_data_i,
  input  logic         ad_last_i,
  output logic         ad_ready_o,
  input  logic         ct_valid_i,
  input  logic [63:0]  ct_data_i,
  input  logic         ct_last_i,
  input  logic [2:0]   ct_bytes_i,
  output logic         ct_ready_o,
  output logic         pt_valid_o,
  output logic [63:0]  pt_data_o,
  input  logic [127:0] tag_i,
  output logic         done_o,
  output logic         tag_ok_o,
  output logic         busy_o
`ifdef ASCON_DEC_STATE_DBG_EN
  ,
  output logic [319:0] dbg_state_o,
  output logic [3:0]   dbg_round_o
`endif
);

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    AD_WAIT,
    AD_PERM,
    CT_WAIT,
    CT_PERM,
    FINAL
  } fsm_e;

  localparam logic [63:0] IV       = 64'h80400c0600000000;
  localparam logic [3:0]  RA_START = 4'(12 - ROUNDS_A);
  localparam logic [3:0]  RB_START = 4'(12 - ROUNDS_B);
  localparam logic [3:0]  LAST_RND = 4'd11;

  fsm_e         fsm_q;
  logic [319:0] state_q;
  logic [127:0] key_q;
  logic [127:0] tag_q;
  logic [3:0]   round_q;
  logic         adNone_q;
  logic         adLast_q;
  logic         ptValid_q;
  logic [63:0]  ptData_q;
  logic         done_q;
  logic         tagOk_q;

  logic [319:0] state_d;
  logic         lastRound;
  logic [63:0]  s0;
  logic [63:0]  ctXor;
  logic [63:0]  ctMask;
  logic [63:0]  ctPad;

  function automatic logic [63:0] ror64(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  // One Ascon round: constant addition, bitsliced S-box layer, linear layer.
  // The round constant for index i is {~i, i}, i.e. 8'hF0 - i*8'h0F.
  function automatic logic [319:0] asconRound(input logic [319:0] s, input logic [3:0] idx);
    logic [63:0] x0, x1, x2, x3, x4;
    logic [63:0] t0, t1, t2, t3, t4;
    {x0, x1, x2, x3, x4} = s;
    x2 = x2 ^ {56'd0, ~idx, idx};
    x0 = x0 ^ x4;
    x4 = x4 ^ x3;
    x2 = x2 ^ x1;
    t0 = ~x0 & x1;
    t1 = ~x1 & x2;
    t2 = ~x2 & x3;
    t3 = ~x3 & x4;
    t4 = ~x4 & x0;
    x0 = x0 ^ t1;
    x1 = x1 ^ t2;
    x2 = x2 ^ t3;
    x3 = x3 ^ t4;
    x4 = x4 ^ t0;
    x1 = x1 ^ x0;
    x0 = x0 ^ x4;
    x3 = x3 ^ x2;
    x2 = ~x2;
    x0 = x0 ^ ror64(x0, 19) ^ ror64(x0, 28);
    x1 = x1 ^ ror64(x1, 61) ^ ror64(x1, 39);
    x2 = x2 ^ ror64(x2, 1)  ^ ror64(x2, 6);
    x3 = x3 ^ ror64(x3, 10) ^ ror64(x3, 17);
    x4 = x4 ^ ror64(x4, 7)  ^ ror64(x4, 41);
    return {x0, x1, x2, x3, x4};
  endfunction

  assign state_d   = asconRound(state_q, round_q);
  assign lastRound = (round_q == LAST_RND);
  assign s0        = state_q[319:256];
  assign ctXor     = s0 ^ ct_data_i;
  // Last beat: mask covers the top n bytes, pad marks byte n (7-n == ~n).
  assign ctMask    = ~(64'hFFFF_FFFF_FFFF_FFFF >> {ct_bytes_i, 3'b000});
  assign ctPad     = 64'h80 << {~ct_bytes_i, 3'b000};

  always_ff @(posedge clock_i) begin
    if (resetb_i) begin
      fsm_q     <= IDLE;
      state_q   <= '0;
      key_q     <= '0;
      tag_q     <= '0;
      round_q   <= '0;
      adNone_q  <= 1'b0;
      adLast_q  <= 1'b0;
      ptValid_q <= 1'b0;
      ptData_q  <= '0;
      done_q    <= 1'b0;
      tagOk_q   <= 1'b0;
    end else begin
      ptValid_q <= 1'b0;
      done_q    <= 1'b0;
      unique case (fsm_q)
        IDLE: begin
          if (start_i) begin
            state_q  <= {IV, key_i, nonce_i};
            key_q    <= key_i;
            adNone_q <= ad_none_i;
            tagOk_q  <= 1'b0;
            round_q  <= RA_START;
            fsm_q    <= INIT;
          end
        end
        INIT: begin
          if (lastRound) begin
            // Key into S3/S4; with no AD the domain bit is applied right away.
            state_q <= state_d ^ {192'd0, key_q} ^ {319'd0, adNone_q};
            round_q <= '0;
            fsm_q   <= adNone_q ? CT_WAIT : AD_WAIT;
          end else begin
            state_q <= state_d;
            round_q <= round_q + 4'd1;
          end
        end
        AD_WAIT: begin
          if (ad_valid_i) begin
            state_q[319:256] <= s0 ^ ad_data_i;
            adLast_q         <= ad_last_i;
            round_q          <= RB_START;
            fsm_q            <= AD_PERM;
          end
        end
        AD_PERM: begin
          if (lastRound) begin
            state_q <= state_d ^ {319'd0, adLast_q};
            round_q <= '0;
            fsm_q   <= adLast_q ? CT_WAIT : AD_WAIT;
          end else begin
            state_q <= state_d;
            round_q <= round_q + 4'd1;
          end
        end
        CT_WAIT: begin
          if (ct_valid_i) begin
            ptValid_q <= 1'b1;
            if (!ct_last_i) begin
              ptData_q         <= ctXor;
              state_q[319:256] <= ct_data_i;
              round_q          <= RB_START;
              fsm_q            <= CT_PERM;
            end else begin
              ptData_q         <= ctXor & ctMask;
              state_q[319:256] <= ((ct_data_i & ctMask) | (s0 & ~ctMask)) ^ ctPad;
              state_q[255:128] <= state_q[255:128] ^ key_q;
              tag_q            <= tag_i;
              round_q          <= RA_START;
              fsm_q            <= FINAL;
            end
          end
        end
        CT_PERM: begin
          if (lastRound) begin
            round_q <= '0;
            fsm_q   <= CT_WAIT;
          end else begin
            round_q <= round_q + 4'd1;
          end
          state_q <= state_d;
        end
        FINAL: begin
          state_q <= state_d;
          if (lastRound) begin
            tagOk_q <= ((state_d[127:0] ^ key_q) == tag_q);
            done_q  <= 1'b1;
            round_q <= '0;
            fsm_q   <= IDLE;
          end else begin
            round_q <= round_q + 4'd1;
          end
        end
        default: fsm_q <= IDLE;
      endcase
    end
  end

  assign ad_ready_o = (fsm_q == AD_WAIT);
  assign ct_ready_o = (fsm_q == CT_WAIT);
  assign busy_o     = (fsm_q != IDLE);
  assign pt_valid_o = ptValid_q;
  assign pt_data_o  = ptData_q;
  assign done_o     = done_q;
  assign tag_ok_o   = tagOk_q;

`ifdef ASCON_DEC_STATE_DBG_EN
  assign dbg_state_o = state_q;
  assign dbg_round_o = round_q;
`endif

endmodule

// File: tb/tb_ascon_decrypt_core.sv
// ---------------------------------------------------------------------------
// tb_ascon_decrypt_core
//
// Bench for ascon_decrypt_core. Messages are produced by an Ascon-128
// encryption model (table-driven S-box, word-level sponge) and fed back
// through the decryptor; expected plaintext beats and tag results go into
// queues that an independent monitor pops whenever the DUT presents output.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ascon_decrypt_core;

  localparam int ROUNDS_A = 12;
  localparam int ROUNDS_B = 6;
  localparam logic [127:0] KAT_KEY = 128'h000102030405060708090A0B0C0D0E0F;
  localparam logic [127:0] KAT_TAG = 128'hE355159F292911F794CB1432A0103A8A;
  localparam logic [63:0]  SPEC_AD = 64'h3230323380000000;
  localparam logic [4:0] SBOX [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};

  logic         clock = 1'b0;
  logic         resetb;
  logic         startIn;
  logic [127:0] keyIn;
  logic [127:0] nonceIn;
  logic         adNoneIn;
  logic         adValid;
  logic [63:0]  adData;
  logic         adLast;
  logic         adReady;
  logic         ctValid;
  logic [63:0]  ctData;
  logic         ctLast;
  logic [2:0]   ctBytes;
  logic         ctReady;
  logic         ptValid;
  logic [63:0]  ptData;
  logic [127:0] tagIn;
  logic         done;
  logic         tagOk;
  logic         busy;

  always #5 clock = ~clock;

  ascon_decrypt_core #(.ROUNDS_A(ROUNDS_A), .ROUNDS_B(ROUNDS_B)) dut (
    .clock_i   (clock),
    .resetb_i  (resetb),
    .start_i   (startIn),
    .key_i     (keyIn),
    .nonce_i   (nonceIn),
    .ad_none_i (adNoneIn),
    .ad_valid_i(adValid),
    .ad_data_i (adData),
    .ad_last_i (adLast),
    .ad_ready_o(adReady),
    .ct_valid_i(ctValid),
    .ct_data_i (ctData),
    .ct_last_i (ctLast),
    .ct_bytes_i(ctBytes),
    .ct_ready_o(ctReady),
    .pt_valid_o(ptValid),
    .pt_data_o (ptData),
    .tag_i     (tagIn),
    .done_o    (done),
    .tag_ok_o  (tagOk),
    .busy_o    (busy)
  );

  int checkCount = 0;
  int passCount  = 0;

  logic [63:0] ptExpQ[$];
  logic        doneExpQ[$];
  logic [63:0] adBlocks[$];
  logic [63:0] ptBlocks[$];
  logic [63:0] ctBlocks[$];

  task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
  endtask

  // ---------------- reference model ----------------
  function automatic logic [63:0] rotr(input logic [63:0] x, input int n);
    logic [127:0] d;
    d = {x, x};
    return d[n +: 64];
  endfunction

  function automatic logic [319:0] refPerm(input logic [319:0] st, input int rounds);
    logic [63:0]  x [5];
    logic [63:0]  y [5];
    logic [4:0]   col;
    logic [4:0]   sub;
    logic [319:0] res;
    for (int w = 0; w < 5; w++) x[w] = st[319-64*w -: 64];
    for (int r = 12 - rounds; r < 12; r++) begin
      x[2] = x[2] ^ 64'((240 - 15 * r) & 255);
      for (int b = 0; b < 64; b++) begin
        col = {x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]};
        sub = SBOX[col];
        for (int w = 0; w < 5; w++) y[w][b] = sub[4-w];
      end
      x[0] = y[0] ^ rotr(y[0], 19) ^ rotr(y[0], 28);
      x[1] = y[1] ^ rotr(y[1], 61) ^ rotr(y[1], 39);
      x[2] = y[2] ^ rotr(y[2], 1)  ^ rotr(y[2], 6);
      x[3] = y[3] ^ rotr(y[3], 10) ^ rotr(y[3], 17);
      x[4] = y[4] ^ rotr(y[4], 7)  ^ rotr(y[4], 41);
    end
    for (int w = 0; w < 5; w++) res[319-64*w -: 64] = x[w];
    return res;
  endfunction

  function automatic logic [63:0] topBytesMask(input int n);
    logic [63:0] m;
    m = '0;
    for (int i = 0; i < n; i++) m[63-8*i -: 8] = 8'hFF;
    return m;
  endfunction

  // Ascon-128 encryption of adBlocks / ptBlocks plus an n-byte tail.
  task automatic encryptModel(input logic [127:0] key, input logic [127:0] nonce, input int n,
                              input logic [63:0] lastPt, output logic [63:0] ctTail,
                              output logic [127:0] tag);
    logic [319:0] s;
    logic [63:0]  padded;
    ctBlocks.delete();
    s = {64'h80400c0600000000, key, nonce};
    s = refPerm(s, ROUNDS_A);
    s[127:0] ^= key;
    foreach (adBlocks[i]) begin
      s[319:256] ^= adBlocks[i];
      s = refPerm(s, ROUNDS_B);
    end
    s[0] ^= 1'b1;
    foreach (ptBlocks[i]) begin
      s[319:256] ^= ptBlocks[i];
      ctBlocks.push_back(s[319:256]);
      s = refPerm(s, ROUNDS_B);
    end
    padded = lastPt & topBytesMask(n);
    padded[63-8*n -: 8] = 8'h80;
    s[319:256] ^= padded;
    ctTail = s[319:256] & topBytesMask(n);
    s[255:128] ^= key;
    s = refPerm(s, ROUNDS_A);
    tag = s[127:0] ^ key;
  endtask

  // ---------------- drivers (entered and left on a falling edge) ----------------
  task automatic startRun(input logic [127:0] key, input logic [127:0] nonce, input logic adNone);
    startIn  = 1'b1;
    keyIn    = key;
    nonceIn  = nonce;
    adNoneIn = adNone;
    @(negedge clock);
    startIn = 1'b0;
  endtask

  task automatic sendAd(input logic [63:0] data, input logic last);
    int waited = 0;
    adValid = 1'b1;
    adData  = data;
    adLast  = last;
    while (!adReady && waited < 200) begin
      @(negedge clock);
      waited++;
    end
    if (!adReady) begin
      checkOutput("ad_ready_o timeout", 128'(adReady), 128'd1);
      adValid = 1'b0;
      return;
    end
    @(negedge clock);
    adValid = 1'b0;
  endtask

  task automatic sendCt(input logic [63:0] data, input logic last, input logic [2:0] bytes,
                        input logic [127:0] tag, input logic holdValid, output int gap);
    gap     = 0;
    ctValid = 1'b1;
    ctData  = data;
    ctLast  = last;
    ctBytes = bytes;
    tagIn   = tag;
    while (!ctReady && gap < 200) begin
      @(negedge clock);
      gap++;
    end
    if (!ctReady) begin
      checkOutput("ct_ready_o timeout", 128'(ctReady), 128'd1);
      ctValid = 1'b0;
      return;
    end
    @(negedge clock);
    ctValid = holdValid;
  endtask

  task automatic waitDone();
    int waited = 0;
    while (doneExpQ.size() != 0 && waited < 100) begin
      @(negedge clock);
      waited++;
    end
    if (doneExpQ.size() != 0) begin
      checkOutput("done_o timeout", 128'(doneExpQ.size()), 128'd0);
      doneExpQ.delete();
      ptExpQ.delete();
    end
  endtask

  // One complete decryption of the message held in adBlocks/ptBlocks.
  task automatic applyStimulus(input logic [127:0] key, input logic [127:0] nonce, input int n,
                               input logic [63:0] lastPt, input logic useFixedTag,
                               input logic [127:0] fixedTag, input logic expOk,
                               input logic holdValid, input logic pokeStart);
    logic [63:0]  ctTail;
    logic [63:0]  junk;
    logic [127:0] modelTag;
    logic [127:0] tagDrive;
    int           gap;
    encryptModel(key, nonce, n, lastPt, ctTail, modelTag);
    if (useFixedTag) tagDrive = fixedTag;
    else tagDrive = expOk ? modelTag : modelTag ^ (128'd1 << $urandom_range(127));
    foreach (ptBlocks[i]) ptExpQ.push_back(ptBlocks[i]);
    ptExpQ.push_back(lastPt & topBytesMask(n));
    doneExpQ.push_back(expOk);
    startRun(key, nonce, adBlocks.size() == 0);
    if (pokeStart) startRun(~key, ~nonce, 1'b1);
    foreach (adBlocks[i]) sendAd(adBlocks[i], i == adBlocks.size() - 1);
    for (int i = 0; i < ptBlocks.size(); i++) begin
      sendCt(ctBlocks[i], 1'b0, 3'd0, tagDrive, holdValid, gap);
      if (i > 0) checkOutput("ct_ready_o low cycles", 128'(gap), 128'(ROUNDS_B));
    end
    junk = {$urandom, $urandom};
    sendCt(ctTail | (junk & ~topBytesMask(n)), 1'b1, 3'(n), tagDrive, 1'b0, gap);
    if (ptBlocks.size() > 0) checkOutput("ct_ready_o low cycles", 128'(gap), 128'(ROUNDS_B));
    if (pokeStart) begin
      startIn = 1'b1;
      keyIn   = ~key;
      @(negedge clock);
      startIn = 1'b0;
    end
    waitDone();
    repeat (2) @(negedge clock);
    checkOutput("tag_ok_o held", 128'(tagOk), 128'(expOk));
  endtask

  task automatic resetMidRun();
    logic [127:0] key;
    logic [127:0] nonce;
    logic [63:0]  ctTail;
    logic [127:0] modelTag;
    int           gap;
    key   = {$urandom, $urandom, $urandom, $urandom};
    nonce = {$urandom, $urandom, $urandom, $urandom};
    adBlocks.delete();
    ptBlocks.delete();
    ptBlocks.push_back({$urandom, $urandom});
    ptBlocks.push_back({$urandom, $urandom});
    encryptModel(key, nonce, 3, 64'h0, ctTail, modelTag);
    ptExpQ.push_back(ptBlocks[0]);
    startRun(key, nonce, 1'b1);
    sendCt(ctBlocks[0], 1'b0, 3'd0, modelTag, 1'b0, gap);
    repeat (2) @(negedge clock);
    resetb = 1'b1;
    @(negedge clock);
    checkOutput("busy_o after mid-run reset", 128'(busy), 128'd0);
    resetb = 1'b0;
    repeat (30) @(negedge clock);
    checkOutput("pt beats after mid-run reset", 128'(ptExpQ.size()), 128'd0);
    applyStimulus(key, nonce, 3, {$urandom, $urandom}, 1'b0, '0, 1'b1, 1'b0, 1'b0);
  endtask

  // ---------------- monitor ----------------
  initial begin : monitor
    logic [63:0] expPt;
    logic        expOk;
    forever begin
      @(negedge clock);
      if (ptValid) begin
        if (ptExpQ.size() == 0) checkOutput("pt_valid_o unexpected", 128'(ptValid), 128'd0);
        else begin
          expPt = ptExpQ.pop_front();
          checkOutput("pt_data_o", 128'(ptData), 128'(expPt));
        end
      end
      if (done) begin
        if (doneExpQ.size() == 0) checkOutput("done_o unexpected", 128'(done), 128'd0);
        else begin
          expOk = doneExpQ.pop_front();
          checkOutput("tag_ok_o", 128'(tagOk), 128'(expOk));
        end
      end
    end
  end

  initial begin : watchdog
    repeat (50000) @(posedge clock);
    $display("[TB] FAIL watchdog: run did not finish, got timeout, expected completion");
    $display("%0d/%0d checks passed", passCount, checkCount + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin : stimulus
    logic [127:0] key;
    logic [127:0] nonce;
    int           adCount;
    int           ptCount;
    startIn = 1'b0; keyIn = '0; nonceIn = '0; adNoneIn = 1'b0;
    adValid = 1'b0; adData = '0; adLast = 1'b0;
    ctValid = 1'b0; ctData = '0; ctLast = 1'b0; ctBytes = '0; tagIn = '0;
    resetb = 1'b1;
    repeat (3) @(negedge clock);
    checkOutput("reset busy_o", 128'(busy), 128'd0);
    checkOutput("reset ad_ready_o", 128'(adReady), 128'd0);
    checkOutput("reset ct_ready_o", 128'(ctReady), 128'd0);
    checkOutput("reset pt_valid_o", 128'(ptValid), 128'd0);
    checkOutput("reset pt_data_o", 128'(ptData), 128'd0);
    checkOutput("reset done_o", 128'(done), 128'd0);
    checkOutput("reset tag_ok_o", 128'(tagOk), 128'd0);
    resetb = 1'b0;
    @(negedge clock);

    // Known-answer vector: empty AD, empty message.
    adBlocks.delete();
    ptBlocks.delete();
    applyStimulus(KAT_KEY, KAT_KEY, 0, 64'h0, 1'b1, KAT_TAG, 1'b1, 1'b0, 1'b0);
    applyStimulus(KAT_KEY, KAT_KEY, 0, 64'h0, 1'b1, KAT_TAG ^ 128'd1, 1'b0, 1'b0, 1'b0);

    // One AD block, three full beats, 5-byte tail; valid held high, start poked while busy.
    adBlocks.delete();
    adBlocks.push_back(SPEC_AD);
    ptBlocks.delete();
    for (int i = 0; i < 3; i++) ptBlocks.push_back({$urandom, $urandom});
    key   = {$urandom, $urandom, $urandom, $urandom};
    nonce = {$urandom, $urandom, $urandom, $urandom};
    applyStimulus(key, nonce, 5, {$urandom, $urandom}, 1'b0, '0, 1'b1, 1'b1, 1'b1);

    resetMidRun();

    for (int run = 0; run < 8; run++) begin
      adBlocks.delete();
      ptBlocks.delete();
      adCount = $urandom_range(3);
      ptCount = $urandom_range(3);
      for (int i = 0; i < adCount; i++) adBlocks.push_back({$urandom, $urandom});
      for (int i = 0; i < ptCount; i++) ptBlocks.push_back({$urandom, $urandom});
      key   = {$urandom, $urandom, $urandom, $urandom};
      nonce = {$urandom, $urandom, $urandom, $urandom};
      applyStimulus(key, nonce, $urandom_range(7), {$urandom, $urandom}, 1'b0, '0,
                    1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)));
    end

    repeat (5) @(negedge clock);
    checkOutput("pt queue drained", 128'(ptExpQ.size()), 128'd0);
    checkOutput("done queue drained", 128'(doneExpQ.size()), 128'd0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
